// File: rtl/cpu4_pkg.sv
// cpu4_pkg: shared widths, opcodes, instruction field positions and FSM states for the 4-bit CPU core.
// The optional overflow helper is compiled only when ALU_ISSUE_OVF_FLAG_EN is defined.
package cpu4_pkg;
  localparam int DATA_W    = 4;
  localparam int NREGS     = 4;
  localparam int REG_IDX_W = $clog2(NREGS);
  localparam int INSTR_W   = 8;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_NAND = 2'b01;
  localparam logic [1:0] OP_LDI  = 2'b10;
  localparam logic [1:0] OP_CMP  = 2'b11;

  localparam int OP_LSB  = 6;
  localparam int RD_LSB  = 4;
  localparam int RA_LSB  = 2;
  localparam int RB_LSB  = 0;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

`ifdef ALU_ISSUE_OVF_FLAG_EN
  // Signed overflow of a two's-complement add: like-signed operands, differently-signed result.
  function automatic logic add_ovf(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                   input logic [DATA_W-1:0] res);
    return (a[DATA_W-1] == b[DATA_W-1]) && (res[DATA_W-1] != a[DATA_W-1]);
  endfunction
`endif
endpackage

// File: rtl/cpu4_regfile.sv
// cpu4_regfile: NREGS x DATA_W register file, two combinational operand reads, one debug read, one synchronous write.
module cpu4_regfile
  import cpu4_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_we,
  input  logic [REG_IDX_W-1:0] i_waddr,
  input  logic [DATA_W-1:0]    i_wdata,
  input  logic [REG_IDX_W-1:0] i_raddr_a,
  input  logic [REG_IDX_W-1:0] i_raddr_b,
  input  logic [REG_IDX_W-1:0] i_dbg_idx,
  output logic [DATA_W-1:0]    o_rdata_a,
  output logic [DATA_W-1:0]    o_rdata_b,
  output logic [DATA_W-1:0]    o_dbg_data
);
  logic [NREGS-1:0][DATA_W-1:0] r_regs;

  // Storage: cleared asynchronously, written on the clock edge when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_regs <= '0;
    else if (i_we) r_regs[i_waddr] <= i_wdata;
  end

  assign o_rdata_a  = r_regs[i_raddr_a];
  assign o_rdata_b  = r_regs[i_raddr_b];
  assign o_dbg_data = r_regs[i_dbg_idx];
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: IDLE/EXEC/WB sequencer that issues operands to an external 4-bit ALU and writes results back.
// Optional ovf_flag output is enabled by defining ALU_ISSUE_OVF_FLAG_EN.
module alu_issue_ctrl
  import cpu4_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [INSTR_W-1:0]   instr,
  output logic [DATA_W-1:0]    alu_a,
  output logic [DATA_W-1:0]    alu_b,
  output logic                 alu_sel,
  input  logic [DATA_W-1:0]    alu_res,
  input  logic                 alu_eq,
  output logic                 eq_flag,
  output logic                 done,
  input  logic [REG_IDX_W-1:0] dbg_idx,
  output logic [DATA_W-1:0]    dbg_data
`ifdef ALU_ISSUE_OVF_FLAG_EN
  ,
  output logic                 ovf_flag
`endif
);
  state_t               r_state, w_next;
  logic [INSTR_W-1:0]   r_instr;
  logic                 w_accept, w_wb, w_we;
  logic [1:0]           w_op, w_in_op;
  logic [DATA_W-1:0]    w_rd_a, w_rd_b, w_wdata;

  assign w_op    = r_instr[OP_LSB +: 2];
  assign w_in_op = instr[OP_LSB +: 2];
  assign w_we    = w_wb && (w_op != OP_CMP);
  assign w_wdata = (w_op == OP_LDI) ? r_instr[IMM_LSB +: DATA_W] : alu_res;

  cpu4_regfile u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_we       (w_we),
    .i_waddr    (r_instr[RD_LSB +: REG_IDX_W]),
    .i_wdata    (w_wdata),
    .i_raddr_a  (instr[RA_LSB +: REG_IDX_W]),
    .i_raddr_b  (instr[RB_LSB +: REG_IDX_W]),
    .i_dbg_idx  (dbg_idx),
    .o_rdata_a  (w_rd_a),
    .o_rdata_b  (w_rd_b),
    .o_dbg_data (dbg_data)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  end

  // Next state plus handshake/writeback strobes.
  always_comb begin
    w_next      = r_state;
    instr_ready = 1'b0;
    w_accept    = 1'b0;
    w_wb        = 1'b0;
    case (r_state)
      S_IDLE: begin
        instr_ready = 1'b1;
        w_accept    = instr_valid;
        w_next      = instr_valid ? S_EXEC : S_IDLE;
      end
      S_EXEC: w_next = S_WB;
      S_WB: begin
        w_wb   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Latch the instruction and register the ALU operands on entry to EXEC; capture flags leaving WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= 1'b0;
      eq_flag <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= w_wb;
      if (w_accept) begin
        r_instr <= instr;
        alu_a   <= w_rd_a;
        alu_b   <= w_rd_b;
        alu_sel <= (w_in_op == OP_NAND);
      end
      if (w_wb && (w_op inside {OP_ADD, OP_NAND, OP_CMP})) eq_flag <= alu_eq;
    end
  end

`ifdef ALU_ISSUE_OVF_FLAG_EN
  // Overflow flag: set from the add result for ADD/CMP, cleared by NAND, held by LDI.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_flag <= 1'b0;
    else if (w_wb && (w_op == OP_ADD || w_op == OP_CMP)) ovf_flag <= add_ovf(alu_a, alu_b, alu_res);
    else if (w_wb && w_op == OP_NAND) ovf_flag <= 1'b0;
  end
`endif
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequencer directly upstream and downstream of the 4-bit ALU (combinational; ports A, B, sel, RES, eq).
- Accepts 8-bit instructions over a valid/ready handshake and reads operands from a local 4x4-bit register file.
- Drives the ALU operand and select lines, then captures RES into the destination register and eq into a flag register.
- Forms the execute/writeback core of the 4-bit CPU.

Parameters:
- DATA_W, 4, operand/result width; must equal ALU width.
- NREGS, 4, register count; register index width = log2(NREGS) = 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  controller can accept an instruction.
- instr  in  8  [7:6] opcode, [5:4] rd, [3:2] ra, [1:0] rb.
- alu_a  out  DATA_W  to ALU A.
- alu_b  out  DATA_W  to ALU B.
- alu_sel  out  1  to ALU sel (0 = add, 1 = nand).
- alu_res  in  DATA_W  from ALU RES.
- alu_eq  in  1  from ALU eq (A == B).
- eq_flag  out  1  registered eq of last ADD/NAND/CMP.
- done  out  1  one-cycle pulse at writeback.
- dbg_idx  in  2  debug read index.
- dbg_data  out  DATA_W  combinational read of reg[dbg_idx].

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: all registers 0, eq_flag 0, done 0, state IDLE, latched instruction 0, alu_a/alu_b 0, alu_sel 0.
- Opcodes:
  - 00 ADD: rd = ra + rb, mod 16, no carry out.
  - 01 NAND: rd = ~(ra & rb).
  - 10 LDI: rd = imm4 = instr[3:0]; ALU not used; eq_flag unchanged.
  - 11 CMP: ALU driven as ADD; no register write; eq_flag updated.
- FSM states: IDLE, EXEC, WB.
  - IDLE: instr_ready = 1. If instr_valid, latch instr and go to EXEC.
  - EXEC: instr_ready = 0. alu_a = reg[ra] and alu_b = reg[rb], both registered from the latched instruction. alu_sel = opcode[0] for ADD/NAND, 0 for CMP/LDI. Go to WB.
  - WB: sample alu_res and alu_eq (ALU is combinational and settles within EXEC/WB). Write rd unless CMP; LDI writes imm. done = 1. Go to IDLE.
- Latency and throughput: accept edge to done = 2 cycles; written value visible on dbg_data the cycle after WB. One instruction per 3 cycles.
- alu_a/alu_b/alu_sel hold their values outside EXEC/WB; they change only on entry to EXEC.
- rd == ra or rd == rb: operands are read in EXEC, before the write in WB, so there is no hazard.
- instr_valid while not ready: ignored. The source must hold instr until it sees the accept.
- Reset mid-instruction: state returns to IDLE and the pending write is dropped. done must not pulse.
- instr_valid stuck high: a new instruction is accepted on every IDLE cycle, back-to-back.

Optional Feature:
- Macro ALU_ISSUE_OVF_FLAG_EN.
- When defined: adds output port ovf_flag (1 bit, reset 0), updated in WB for ADD/CMP as (a[3] == b[3]) && (res[3] != a[3]). Cleared by NAND; held by LDI.
- When undefined: port absent; no overflow logic.

Decomposition:
- Shared package cpu4_pkg:
  - DATA_W, REG_IDX_W.
  - Opcode constants OP_ADD/OP_NAND/OP_LDI/OP_CMP.
  - FSM state enum.
  - Instruction field bit positions.
- Sub-module cpu4_regfile: NREGS x DATA_W, two combinational read ports plus the debug read port, one synchronous write port, async reset to 0.

Test Plan:
- LDI r1=0xF, LDI r2=0xB, ADD r3=r1+r2 -> reg3 = 0xA (-6), eq_flag = 0, done pulses 2 cycles after each accept.
- LDI r0=0xE, NAND r1=r0,r0 -> reg1 = 0x1, eq_flag = 1, alu_sel = 1 during EXEC.
- LDI r1=0x8, LDI r2=0xD, ADD r3 -> reg3 = 0x5; with ALU_ISSUE_OVF_FLAG_EN, ovf_flag = 1.
- LDI r1=0x5, CMP r1,r1 -> eq_flag = 1, no register changes, ovf_flag = 1 (0x5 + 0x5 = 0xA). Then NAND -> ovf_flag = 0.
- instr_valid held high with 4 queued LDIs -> instr_ready pulses every 3rd cycle, all 4 registers written in order.
- rst_n asserted during EXEC of ADD r3 -> reg3 stays 0, done never pulses, instr_ready = 1 after release.
